// File: rtl/dmem_bridge.sv
// dmem_bridge: data-side memory stage that serves word loads and stores from an internal RAM or a peripheral port.
// Optional peripheral timeout with a sticky bus-error flag is enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bridge #(
    parameter int unsigned RAM_WORDS      = 1024,
    parameter logic [31:0] PERIPH_BASE    = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] WData_i,
    output logic [31:0] ReadData_o,
    output logic        Stall_o,
    output logic        PReq_o,
    output logic        PWe_o,
    output logic [15:0] PAddr_o,
    output logic [31:0] PWData_o,
    input  logic [31:0] PRData_i,
    input  logic        PAck_i,
    output logic        BusErr_o
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    // Elaboration-time range checks; an illegal configuration yields a visible empty block.
    if (RAM_WORDS < 2 || (RAM_WORDS & (RAM_WORDS - 1)) != 0) begin : g_bad_ram_words
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    end

    typedef enum logic [1:0] {
        IDLE,
        RAM_RD,
        P_REQ,
        P_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem [RAM_WORDS];
    logic [31:0]   ram_q;
    logic [31:0]   rdata_q;
    logic [AW-1:0] ram_idx;
    logic          req;
    logic          is_periph;
    logic          timeout_hit;

    // No access can issue while reset is held, so stall and RAM writes are gated by it too.
    assign req       = (MemRead_i | MemWrite_i) & reset_i;
    assign is_periph = (Addr_i[31:16] == PERIPH_BASE[31:16]);
    assign ram_idx   = Addr_i[AW+1:2];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            // NOTE: all registered state uses non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        Stall_o    = 1'b0;
        ReadData_o = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (is_periph) begin
                        state_d = P_REQ;
                        Stall_o = 1'b1;
                    end else if (!MemWrite_i) begin
                        state_d = RAM_RD;
                        Stall_o = 1'b1;
                    end
                end
            end
            RAM_RD: begin
                state_d    = IDLE;
                ReadData_o = ram_q;
            end
            P_REQ: begin
                Stall_o = 1'b1;
                if (PAck_i || timeout_hit) begin
                    state_d = P_DONE;
                end
            end
            P_DONE: begin
                state_d    = IDLE;
                ReadData_o = rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the RAM array and its read register have no reset; contents must survive a core reset.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && req && !is_periph) begin
            if (MemWrite_i) begin
                mem[ram_idx] <= WData_i;
            end else begin
                ram_q <= mem[ram_idx];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            PReq_o   <= 1'b0;
            PWe_o    <= 1'b0;
            PAddr_o  <= 16'h0;
            PWData_o <= 32'h0;
            rdata_q  <= 32'h0;
        end else if (state_q == IDLE && req && is_periph) begin
            PReq_o   <= 1'b1;
            PWe_o    <= MemWrite_i;
            PAddr_o  <= Addr_i[15:0];
            PWData_o <= WData_i;
        end else if (state_q == P_REQ) begin
            // An acknowledge on the terminal cycle takes priority over the timeout.
            if (PAck_i) begin
                PReq_o  <= 1'b0;
                rdata_q <= PRData_i;
            end else if (timeout_hit) begin
                PReq_o  <= 1'b0;
                rdata_q <= 32'hDEAD_BEEF;
            end
        end
    end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    logic        bus_err_q;

    // to_cnt_q holds the number of P_REQ cycles already completed.
    assign timeout_hit = (state_q == P_REQ) && !PAck_i && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign BusErr_o    = bus_err_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            to_cnt_q  <= 16'h0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_q != P_REQ && state_d == P_REQ) begin
                to_cnt_q <= 16'h0;
            end else if (state_q == P_REQ) begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end
            if (timeout_hit) begin
                bus_err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign BusErr_o    = 1'b0;
`endif

endmodule
